// File: rtl/nn_pkg.sv
// Shared constants, weight-row type and the 17-to-16-bit saturation helper
// used by the training-side weight updater.
package nn_pkg;

  localparam int NUM_PIXELS  = 784;
  localparam int NUM_CLASSES = 10;
  localparam int ADDR_W      = 10;

  typedef shortint weight_row_t [9:0];

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } wu_state_t;

  // Top two bits disagree exactly when the value does not fit in 16 bits.
  function automatic shortint sat16(input logic signed [16:0] v);
    shortint r;
    if (v[16] != v[15]) begin
      r = v[16] ? 16'sh8000 : 16'sh7fff;
    end else begin
      r = shortint'(v[15:0]);
    end
    return r;
  endfunction

endpackage

// File: rtl/weight_update_if.sv
// Bundle between the weight updater, the forward path outputs, the pixel
// buffer and the weight RAM ports.
interface weight_update_if;
  import nn_pkg::*;

  logic              start;
  logic [3:0]        label;
  logic [3:0]        classification;
  weight_row_t       output_test;
  logic [ADDR_W-1:0] pix_addr;
  logic              pixel;
  logic [ADDR_W-1:0] w_rd_addr;
  weight_row_t       w_rd_data;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  weight_row_t       w_wr_data;
  logic              busy;
  logic              done;

  modport master (
    input  start, label, classification, output_test, pixel, w_rd_data,
    output pix_addr, w_rd_addr, w_wr_en, w_wr_addr, w_wr_data, busy, done
  );

  modport slave (
    output start, label, classification, output_test, pixel, w_rd_data,
    input  pix_addr, w_rd_addr, w_wr_en, w_wr_addr, w_wr_data, busy, done
  );

endinterface

// File: rtl/weight_lane_update.sv
// One class lane: saturating add of the latched delta onto a returning weight.
module weight_lane_update
  import nn_pkg::*;
(
  input  shortint weight,
  input  shortint delta,
  output shortint weight_new
);

  logic signed [16:0] sum;

  assign sum        = {weight[15], weight} + {delta[15], delta};
  assign weight_new = sat16(sum);

endmodule

// File: rtl/weight_update.sv
// Backward-pass weight updater: latches the forward outputs, derives one delta
// per class, then streams every pixel row and rewrites rows whose pixel is lit.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for start; inputs captured on the start cycle
// ST_LATCH  | deltas computed into registers; skip-or-stream decision
// ST_STREAM | one read address per cycle, 0 .. NUM_PIXELS-1
// ST_DRAIN  | address held while the read pipeline empties
// ST_DONE   | one-cycle done pulse
module weight_update
  import nn_pkg::*;
#(
  parameter int TARGET            = 256,
  parameter int LR_SHIFT          = 4,
  parameter int RD_LATENCY        = 2,
  parameter bit UPDATE_ON_CORRECT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  weight_update_if.master bus
);

  localparam int                CNT_W     = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  wu_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [3:0]        label_q, label_d;
  logic [3:0]        class_q, class_d;
  weight_row_t       outs_q, outs_d;
  weight_row_t       delta_q, delta_d;
  logic [RD_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
  logic [ADDR_W-1:0] pipe_addr_q [RD_LATENCY];
  logic [ADDR_W-1:0] pipe_addr_d [RD_LATENCY];
  weight_row_t       rd_data;
  weight_row_t       wr_data;

  // err = target - output in 17 bits, then floor-shift and clamp to 16 bits.
  function automatic shortint calc_delta(input logic is_label, input shortint out_k);
    logic signed [16:0] tgt;
    logic signed [16:0] err;
    tgt = is_label ? 17'(TARGET) : 17'sd0;
    err = tgt - {out_k[15], out_k};
    return sat16(err >>> LR_SHIFT);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      drain_cnt_q  <= '0;
      label_q      <= '0;
      class_q      <= '0;
      pipe_valid_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_addr_q[i] <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) begin
        outs_q[k]  <= '0;
        delta_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      drain_cnt_q  <= drain_cnt_d;
      label_q      <= label_d;
      class_q      <= class_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_addr_q  <= pipe_addr_d;
      outs_q       <= outs_d;
      delta_q      <= delta_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    drain_cnt_d = drain_cnt_q;
    label_d     = label_q;
    class_d     = class_q;
    outs_d      = outs_q;
    delta_d     = delta_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_LATCH;
          label_d = bus.label;
          class_d = bus.classification;
          outs_d  = bus.output_test;
        end
      end
      ST_LATCH: begin
        for (int k = 0; k < NUM_CLASSES; k++) begin
          delta_d[k] = calc_delta(label_q == 4'(k), outs_q[k]);
        end
        addr_d = '0;
        if (!UPDATE_ON_CORRECT && (class_q == label_q)) state_d = ST_DONE;
        else                                             state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (addr_q == LAST_ADDR) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = CNT_W'(RD_LATENCY - 1);
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) state_d = ST_DONE;
        else                   drain_cnt_d = drain_cnt_q - CNT_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Address/valid pair travels alongside the memory read latency.
  always_comb begin
    pipe_valid_d    = pipe_valid_q;
    pipe_addr_d     = pipe_addr_q;
    pipe_valid_d[0] = (state_q == ST_STREAM);
    pipe_addr_d[0]  = addr_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_addr_d[i]  = pipe_addr_q[i-1];
    end
  end

  always_comb rd_data = bus.w_rd_data;

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
    weight_lane_update u_lane (
      .weight     (rd_data[k]),
      .delta      (delta_q[k]),
      .weight_new (wr_data[k])
    );
  end

  always_comb begin
    bus.pix_addr  = addr_q;
    bus.w_rd_addr = addr_q;
    bus.w_wr_en   = pipe_valid_q[RD_LATENCY-1] & bus.pixel;
    bus.w_wr_addr = pipe_addr_q[RD_LATENCY-1];
    bus.w_wr_data = wr_data;
    bus.busy      = (state_q != ST_IDLE);
    bus.done      = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_weight_update.sv
// Randomised bench for weight_update: a pass-level reference model predicts
// every write, busy/done and read address cycle by cycle for two instances.
module tb_weight_update;
  import nn_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  weight_update_if bus0 ();
  weight_update_if bus1 ();

  weight_update #(.UPDATE_ON_CORRECT(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  weight_update #(.UPDATE_ON_CORRECT(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Memories: pixel buffer and weight RAM with a two-cycle read latency.
  bit          pix_mem  [NUM_PIXELS];
  weight_row_t wmem     [NUM_PIXELS];
  weight_row_t init_mem [NUM_PIXELS];
  bit          load_req = 1'b0;
  bit [9:0]    ra0_1, ra0_2, ra1_1, ra1_2;

  always @(posedge clk) begin
    ra0_1 <= bus0.pix_addr;
    ra0_2 <= ra0_1;
    ra1_1 <= bus1.pix_addr;
    ra1_2 <= ra1_1;
    if (load_req) wmem <= init_mem;
    else if (bus0.w_wr_en === 1'b1) wmem[bus0.w_wr_addr] <= bus0.w_wr_data;
  end

  always_comb begin
    bus0.pixel     = pix_mem[ra0_2];
    bus0.w_rd_data = wmem[ra0_2];
    bus1.pixel     = pix_mem[ra1_2];
    bus1.w_rd_data = wmem[ra1_2];
  end

  // Reference model state, one slot per instance (slot 1 skips on correct).
  bit act [2];
  bit skp [2];
  int t [2];
  int tend [2];
  int dl [2][10];

  int tests = 0;
  int fails = 0;
  int wr_cnt [2];
  int done_cnt [2];
  int done_t [2];
  int timeouts = 0;
  int lit_sel = 0;
  bit chk_en = 1'b0;

  function automatic int clamp16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int floor_div16(int e);
    if (e >= 0) return e / 16;
    return -((-e + 15) / 16);
  endfunction

  function automatic weight_row_t rnd_row();
    weight_row_t r;
    for (int k = 0; k < 10; k++) r[k] = shortint'($urandom);
    return r;
  endfunction

  function automatic weight_row_t const_row(int v);
    weight_row_t r;
    for (int k = 0; k < 10; k++) r[k] = shortint'(v);
    return r;
  endfunction

  task automatic model_step(int i, logic st, logic [3:0] lb, logic [3:0] cl, weight_row_t ot);
    int err;
    if (reset) begin
      act[i] = 1'b0;
    end else if (act[i]) begin
      if (t[i] >= tend[i]) act[i] = 1'b0;
      else t[i]++;
    end else if (st) begin
      act[i]  = 1'b1;
      t[i]    = 1;
      skp[i]  = (i == 1) && (lb == cl);
      tend[i] = skp[i] ? 2 : NUM_PIXELS + 4;
      for (int k = 0; k < 10; k++) begin
        err      = ((int'(lb) == k) ? 256 : 0) - int'(ot[k]);
        dl[i][k] = clamp16(floor_div16(err));
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, bus0.start, bus0.label, bus0.classification, bus0.output_test);
    model_step(1, bus1.start, bus1.label, bus1.classification, bus1.output_test);
  end

  task automatic chk(string nm, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_inst(int i, logic busy, logic done, logic wr_en, logic [9:0] wa,
                            logic [9:0] pa, logic [9:0] ra, weight_row_t wd);
    bit eb, ed, ee;
    int a;
    eb = act[i];
    ed = act[i] && (t[i] == tend[i]);
    ee = act[i] && !skp[i] && (t[i] >= 4) && (t[i] <= NUM_PIXELS + 3) && pix_mem[t[i] - 4];
    chk("busy", int'(busy), int'(eb));
    chk("done", int'(done), int'(ed));
    chk("wr_en", int'(wr_en), int'(ee));
    chk("rd_addr_eq_pix_addr", int'(ra), int'(pa));
    if (act[i] && !skp[i] && (t[i] >= 2) && (t[i] <= NUM_PIXELS + 1))
      chk("pix_addr", int'(pa), t[i] - 2);
    if (ee) begin
      a = t[i] - 4;
      chk("wr_addr", int'(wa), a);
      for (int k = 0; k < 10; k++)
        chk("wr_data", int'(wd[k]), clamp16(int'(wmem[a][k]) + dl[i][k]));
    end
    if (act[i] && t[i] == 1) begin
      wr_cnt[i]   = 0;
      done_cnt[i] = 0;
      done_t[i]   = -1;
    end
    if (wr_en === 1'b1) wr_cnt[i]++;
    if (done === 1'b1) begin
      done_cnt[i]++;
      done_t[i] = t[i];
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_inst(0, bus0.busy, bus0.done, bus0.w_wr_en, bus0.w_wr_addr, bus0.pix_addr,
                 bus0.w_rd_addr, bus0.w_wr_data);
      check_inst(1, bus1.busy, bus1.done, bus1.w_wr_en, bus1.w_wr_addr, bus1.pix_addr,
                 bus1.w_rd_addr, bus1.w_wr_data);
      case (lit_sel)
        1: begin
          chk("p1_row5_k3", int'(wmem[5][3]), 116);
          chk("p1_row5_k0", int'(wmem[5][0]), 100);
          chk("p1_row5_k9", int'(wmem[5][9]), 100);
          chk("p1_write_count", wr_cnt[0], 1);
          chk("p1_done_cycle", done_t[0], 788);
        end
        2: begin
          chk("p2_row10_k7", int'(wmem[10][7]), -20);
          chk("p2_row10_k2", int'(wmem[10][2]), 16);
          chk("p2_row10_k0_floor", int'(wmem[10][0]), -1);
          chk("p2_row10_k5", int'(wmem[10][5]), 0);
        end
        3: begin
          chk("p3_sat_high", int'(wmem[20][3]), 32767);
          chk("p3_sat_low", int'(wmem[20][7]), -32768);
        end
        4: begin
          chk("skip_write_count", wr_cnt[1], 0);
          chk("skip_done_cycle", done_t[1], 2);
          chk("skip_done_count", done_cnt[1], 1);
        end
        5: begin
          chk("rst_pix_addr0", int'(bus0.pix_addr), 0);
          chk("rst_wr_addr0", int'(bus0.w_wr_addr), 0);
          chk("rst_pix_addr1", int'(bus1.pix_addr), 0);
        end
        6: chk("pass_timeouts", timeouts, 0);
        default: ;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(int i, logic st, logic [3:0] lb, logic [3:0] cl, weight_row_t ot);
    if (i == 0) begin
      bus0.start = st; bus0.label = lb; bus0.classification = cl; bus0.output_test = ot;
    end else begin
      bus1.start = st; bus1.label = lb; bus1.classification = cl; bus1.output_test = ot;
    end
  endtask

  task automatic set_start(int i, logic st);
    if (i == 0) bus0.start = st;
    else        bus1.start = st;
  endtask

  task automatic set_ot(int i, weight_row_t ot);
    if (i == 0) bus0.output_test = ot;
    else        bus1.output_test = ot;
  endtask

  task automatic pulse_lit(int sel);
    lit_sel = sel;
    tick();
    lit_sel = 0;
  endtask

  task automatic fill_random(int density);
    for (int a = 0; a < NUM_PIXELS; a++) begin
      init_mem[a] = rnd_row();
      pix_mem[a]  = ($urandom_range(0, density - 1) == 0);
    end
  endtask

  task automatic load_mem();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic run_pass(int i, logic [3:0] lb, logic [3:0] cl, weight_row_t ot,
                          int rst_at, int restart_at);
    bit seen;
    seen = 1'b0;
    drive_in(i, 1'b1, lb, cl, ot);
    tick();
    set_start(i, 1'b0);
    for (int n = 1; n <= 1000 && !seen; n++) begin
      set_ot(i, rnd_row());
      set_start(i, n == restart_at);
      if (n == rst_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_start(i, 1'b0);
        pulse_lit(5);
        repeat (3) tick();
        return;
      end
      tick();
      if ((i == 0 && bus0.done === 1'b1) || (i == 1 && bus1.done === 1'b1)) seen = 1'b1;
    end
    set_start(i, 1'b0);
    if (!seen) begin
      timeouts++;
      $display("FAIL pass_wait: no done within 1000 cycles on instance %0d", i);
    end
    repeat (3) tick();
  endtask

  initial begin
    weight_row_t ot;
    drive_in(0, 1'b0, 4'd0, 4'd0, const_row(0));
    drive_in(1, 1'b0, 4'd0, 4'd0, const_row(0));
    for (int a = 0; a < NUM_PIXELS; a++) begin
      init_mem[a] = const_row(0);
      pix_mem[a]  = 1'b0;
    end
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    pulse_lit(5);
    load_mem();
    reset = 1'b0;
    tick();

    // Single lit pixel, zero outputs, label 3.
    fill_random(8);
    for (int a = 0; a < NUM_PIXELS; a++) pix_mem[a] = 1'b0;
    pix_mem[5]  = 1'b1;
    init_mem[5] = const_row(100);
    load_mem();
    run_pass(0, 4'd3, 4'd3, const_row(0), -1, -1);
    pulse_lit(1);

    // Negative delta on a non-label class, floor rounding on a small output.
    fill_random(8);
    pix_mem[10]  = 1'b1;
    init_mem[10] = const_row(0);
    load_mem();
    ot = const_row(0);
    ot[7] = 16'sd320;
    ot[0] = 16'sd5;
    run_pass(0, 4'd2, 4'd7, ot, -1, -1);
    pulse_lit(2);

    // Saturation at both rails.
    fill_random(8);
    pix_mem[20]     = 1'b1;
    init_mem[20][3] = 16'sd32760;
    init_mem[20][7] = -16'sd32760;
    load_mem();
    ot = const_row(0);
    ot[7] = 16'sd320;
    run_pass(0, 4'd3, 4'd7, ot, -1, -1);
    pulse_lit(3);

    // Random passes; the first sees a stray start mid-pass.
    for (int r = 0; r < 2; r++) begin
      fill_random(4);
      load_mem();
      run_pass(0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), rnd_row(),
               -1, (r == 0) ? 100 : -1);
    end

    // Reset in the middle of a pass, then a clean pass over the partial result.
    fill_random(3);
    load_mem();
    run_pass(0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), rnd_row(), 400, -1);
    run_pass(0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), rnd_row(), -1, -1);

    // Skip-on-correct instance: correct classification, second start while busy.
    run_pass(1, 4'd6, 4'd6, rnd_row(), -1, 1);
    pulse_lit(4);

    // Skip-on-correct instance still updates on a misclassification.
    fill_random(5);
    load_mem();
    run_pass(1, 4'd4, 4'd1, rnd_row(), -1, -1);

    pulse_lit(6);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
